// File: rtl/lut_abs_pipe_module.sv
// Sign/magnitude front end for the pipelined LUT multiplier: per-channel two's-complement
// operands become registered unsigned magnitudes plus signs, product sign, zero and clamp flags.
module lut_abs_pipe_module #(
  parameter int WIDTH    = 9,
  parameter int CHANNELS = 2,
  parameter int STAGES   = 2,
  parameter int SAT_MODE = 0,
  parameter int TAG_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_mag,
  output logic [CHANNELS-1:0]       out_sign,
  output logic                      prod_sign,
  output logic                      out_zero,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      ovf
);

  localparam int DW = CHANNELS * WIDTH;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS  = ~MOST_NEG;

  // Source of the output register: raw input (one stage) or the stage-1 register (two stages)
  logic                src_valid;
  logic [DW-1:0]       src_data;
  logic [CHANNELS-1:0] src_sign;
  logic [TAG_W-1:0]    src_tag;

  logic [CHANNELS-1:0] in_sign;
  logic [DW-1:0]       mag_c;
  logic                zero_c;
  logic                ovf_c;
  logic                prod_c;
  logic [WIDTH-1:0]    x_k;
  logic [WIDTH-1:0]    m_k;

  logic                vo;
  logic [DW-1:0]       mag_q;
  logic [CHANNELS-1:0] sign_q;
  logic                prod_q;
  logic                zero_q;
  logic                ovf_q;
  logic [TAG_W-1:0]    tag_q;
  logic                load_o;

  always_comb begin
    in_sign = '0;
    for (int unsigned k = 0; k < CHANNELS; k++)
      in_sign[k] = in_data[k*WIDTH + WIDTH - 1];
  end

  always_comb begin
    mag_c  = '0;
    zero_c = 1'b0;
    ovf_c  = 1'b0;
    x_k    = '0;
    m_k    = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      x_k = src_data[k*WIDTH +: WIDTH];
      m_k = x_k[WIDTH-1] ? ((~x_k) + WIDTH'(1)) : x_k;
      if (SAT_MODE != 0 && x_k == MOST_NEG) begin
        m_k   = MAX_POS;
        ovf_c = 1'b1;
      end
      mag_c[k*WIDTH +: WIDTH] = m_k;
      if (m_k == '0) zero_c = 1'b1;
    end
    prod_c = ^src_sign;
  end

  assign load_o = !vo || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vo     <= 1'b0;
      mag_q  <= '0;
      sign_q <= '0;
      prod_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      tag_q  <= '0;
    end else if (load_o) begin
      vo <= src_valid;
      if (src_valid) begin
        mag_q  <= mag_c;
        sign_q <= src_sign;
        prod_q <= prod_c;
        zero_q <= zero_c;
        ovf_q  <= ovf_c;
        tag_q  <= src_tag;
      end
    end
  end

  if (STAGES == 2) begin : g_two
    logic                v1;
    logic [DW-1:0]       d1;
    logic [CHANNELS-1:0] s1;
    logic [TAG_W-1:0]    t1;
    logic                load_1;

    // Stage 1 refills in the same cycle the output register takes its beat
    assign load_1   = !v1 || load_o;
    assign in_ready = load_1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1 <= 1'b0;
        d1 <= '0;
        s1 <= '0;
        t1 <= '0;
      end else if (load_1) begin
        v1 <= in_valid;
        if (in_valid) begin
          d1 <= in_data;
          s1 <= in_sign;
          t1 <= in_tag;
        end
      end
    end

    assign src_valid = v1;
    assign src_data  = d1;
    assign src_sign  = s1;
    assign src_tag   = t1;
  end else if (STAGES == 1) begin : g_one
    assign in_ready  = load_o;
    assign src_valid = in_valid;
    assign src_data  = in_data;
    assign src_sign  = in_sign;
    assign src_tag   = in_tag;
  end else begin : g_bad
    $error("lut_abs_pipe_module: STAGES must be 1 or 2");
  end

  assign out_valid = vo;
  assign out_mag   = mag_q;
  assign out_sign  = sign_q;
  assign prod_sign = prod_q;
  assign out_zero  = zero_q;
  assign out_tag   = tag_q;
  assign ovf       = ovf_q;

endmodule
